// File: rtl/vproc_wb_responder.sv
// Wishbone classic responder bridging management-SoC firmware to the vector coprocessor:
// command/response FIFOs, a sticky status register, a checkbit GPIO register and an interrupt.
module vproc_wb_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        cmd_valid_o,
   output logic [31:0] cmd_data_o,
   input  logic        cmd_ready_i,
   input  logic        rsp_valid_i,
   input  logic [31:0] rsp_data_i,
   output logic        rsp_ready_o,
   output logic [15:0] gpio_out_o,
   output logic [15:0] gpio_oeb_o,
   output logic        irq_o
);

   localparam int unsigned CmdAw = $clog2(CMD_DEPTH);
   localparam int unsigned RspAw = $clog2(RSP_DEPTH);

   localparam logic [CmdAw:0]   CmdFullCnt = (CmdAw + 1)'(CMD_DEPTH);
   localparam logic [RspAw:0]   RspFullCnt = (RspAw + 1)'(RSP_DEPTH);
   localparam logic [CmdAw:0]   CmdCntOne  = (CmdAw + 1)'(1);
   localparam logic [RspAw:0]   RspCntOne  = (RspAw + 1)'(1);
   localparam logic [CmdAw-1:0] CmdPtrOne  = CmdAw'(1);
   localparam logic [RspAw-1:0] RspPtrOne  = RspAw'(1);

   localparam logic [5:0] OffCmd    = 6'h00;
   localparam logic [5:0] OffRsp    = 6'h01;
   localparam logic [5:0] OffStatus = 6'h02;
   localparam logic [5:0] OffGpio   = 6'h03;
   localparam logic [5:0] OffIrqEn  = 6'h04;

   logic        ack_q;
   logic [31:0] dat_q;
   logic [15:0] gpio_q;
   logic [1:0]  irq_en_q;
   logic        ovf_q, ovf_d;
   logic        udf_q, udf_d;
   logic        irq_q, irq_d;

   logic [31:0]    cmd_mem_q [CMD_DEPTH];
   logic [CmdAw-1:0] cmd_wr_q, cmd_rd_q;
   logic [CmdAw:0]   cmd_cnt_q;
   logic [31:0]    rsp_mem_q [RSP_DEPTH];
   logic [RspAw-1:0] rsp_wr_q, rsp_rd_q;
   logic [RspAw:0]   rsp_cnt_q;

   logic        addr_match, hit, wr_hit, rd_hit;
   logic [5:0]  word;
   logic        cmd_empty, cmd_full, cmd_pop, cmd_wr_req, cmd_push, ovf_set;
   logic        rsp_empty, rsp_full, rsp_push, rsp_rd, rsp_pop, udf_set;
   logic        status_wr, gpio_wr, irq_en_wr;
   logic [31:0] rdata;
   logic [1:0]  unused_adr;

   assign unused_adr = wbs_adr_i[1:0];

   assign addr_match = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign hit        = wbs_stb_i & wbs_cyc_i & addr_match & ~ack_q;
   assign wr_hit     = hit & wbs_we_i;
   assign rd_hit     = hit & ~wbs_we_i;
   assign word       = wbs_adr_i[7:2];

   assign cmd_empty   = (cmd_cnt_q == '0);
   assign cmd_full    = (cmd_cnt_q == CmdFullCnt);
   assign cmd_valid_o = ~cmd_empty;
   assign cmd_data_o  = cmd_mem_q[cmd_rd_q];
   assign cmd_pop     = cmd_valid_o & cmd_ready_i;
   assign cmd_wr_req  = wr_hit & (word == OffCmd) & (wbs_sel_i == 4'hF);
   // A same-cycle pop frees the slot, so a full FIFO can still take the word.
   assign cmd_push    = cmd_wr_req & (~cmd_full | cmd_pop);
   assign ovf_set     = cmd_wr_req & ~cmd_push;

   assign rsp_empty   = (rsp_cnt_q == '0);
   assign rsp_full    = (rsp_cnt_q == RspFullCnt);
   assign rsp_ready_o = ~rsp_full;
   assign rsp_push    = rsp_valid_i & rsp_ready_o;
   assign rsp_rd      = rd_hit & (word == OffRsp);
   assign rsp_pop     = rsp_rd & ~rsp_empty;
   assign udf_set     = rsp_rd & rsp_empty;

   assign status_wr = wr_hit & (word == OffStatus);
   assign gpio_wr   = wr_hit & (word == OffGpio);
   assign irq_en_wr = wr_hit & (word == OffIrqEn) & wbs_sel_i[0];

   // Sticky set beats a coincident write-one-to-clear.
   assign ovf_d = ovf_set | (ovf_q & ~(status_wr & wbs_dat_i[16]));
   assign udf_d = udf_set | (udf_q & ~(status_wr & wbs_dat_i[17]));
   assign irq_d = (irq_en_q[0] & ~rsp_empty) | (irq_en_q[1] & (ovf_q | udf_q));

   always_comb begin
      rdata = '0;
      case (word)
         OffRsp:    rdata = rsp_empty ? '0 : rsp_mem_q[rsp_rd_q];
         OffStatus: rdata = {14'h0, udf_q, ovf_q, 4'h0, 4'(rsp_cnt_q), 4'(cmd_cnt_q),
                             rsp_empty, rsp_full, cmd_empty, cmd_full};
         OffGpio:   rdata = {16'h0, gpio_q};
         OffIrqEn:  rdata = {30'h0, irq_en_q};
         default:   rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         gpio_q   <= '0;
         irq_en_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         ack_q <= hit;
         dat_q <= rd_hit ? rdata : '0;
         if (gpio_wr && wbs_sel_i[0]) gpio_q[7:0]  <= wbs_dat_i[7:0];
         if (gpio_wr && wbs_sel_i[1]) gpio_q[15:8] <= wbs_dat_i[15:8];
         if (irq_en_wr) irq_en_q <= wbs_dat_i[1:0];
         ovf_q <= ovf_d;
         udf_q <= udf_d;
         irq_q <= irq_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int unsigned i = 0; i < CMD_DEPTH; i++) cmd_mem_q[i] <= '0;
         cmd_wr_q  <= '0;
         cmd_rd_q  <= '0;
         cmd_cnt_q <= '0;
      end else begin
         if (cmd_push) begin
            cmd_mem_q[cmd_wr_q] <= wbs_dat_i;
            cmd_wr_q            <= cmd_wr_q + CmdPtrOne;
         end
         if (cmd_pop) cmd_rd_q <= cmd_rd_q + CmdPtrOne;
         if (cmd_push && !cmd_pop) cmd_cnt_q <= cmd_cnt_q + CmdCntOne;
         else if (!cmd_push && cmd_pop) cmd_cnt_q <= cmd_cnt_q - CmdCntOne;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int unsigned i = 0; i < RSP_DEPTH; i++) rsp_mem_q[i] <= '0;
         rsp_wr_q  <= '0;
         rsp_rd_q  <= '0;
         rsp_cnt_q <= '0;
      end else begin
         if (rsp_push) begin
            rsp_mem_q[rsp_wr_q] <= rsp_data_i;
            rsp_wr_q            <= rsp_wr_q + RspPtrOne;
         end
         if (rsp_pop) rsp_rd_q <= rsp_rd_q + RspPtrOne;
         if (rsp_push && !rsp_pop) rsp_cnt_q <= rsp_cnt_q + RspCntOne;
         else if (!rsp_push && rsp_pop) rsp_cnt_q <= rsp_cnt_q - RspCntOne;
      end
   end

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign gpio_out_o = gpio_q;
   assign gpio_oeb_o = 16'h0000;
   assign irq_o      = irq_q;

endmodule

// File: tb/tb_vproc_wb_responder.sv
// Directed bench for vproc_wb_responder: scoreboard queues hold expected command and
// response words; Wishbone accesses are checked for single-cycle ack and read data.
module tb_vproc_wb_responder;

   localparam logic [31:0] Base = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic        ack;
   logic [31:0] rdat;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_data;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [15:0] gpio_out, gpio_oeb;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_cmd_q [$];
   logic [31:0] exp_rsp_q [$];
   logic [15:0] snap_gpio;
   logic        snap_cmd_valid;
   logic [31:0] r;

   always #5 clk = ~clk;

   vproc_wb_responder #(
      .BASE_ADDR(Base),
      .CMD_DEPTH(4),
      .RSP_DEPTH(4)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wbs_stb_i  (stb),
      .wbs_cyc_i  (cyc),
      .wbs_we_i   (we),
      .wbs_sel_i  (sel),
      .wbs_adr_i  (adr),
      .wbs_dat_i  (wdat),
      .wbs_ack_o  (ack),
      .wbs_dat_o  (rdat),
      .cmd_valid_o(cmd_valid),
      .cmd_data_o (cmd_data),
      .cmd_ready_i(cmd_ready),
      .rsp_valid_i(rsp_valid),
      .rsp_data_i (rsp_data),
      .rsp_ready_o(rsp_ready),
      .gpio_out_o (gpio_out),
      .gpio_oeb_o (gpio_oeb),
      .irq_o      (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Core-side consumer: every accepted command word must match the scoreboard head.
   always @(negedge clk) begin
      #2;
      if (!rst && cmd_valid && cmd_ready) begin
         check("cmd_pop_expected", 32'(exp_cmd_q.size() != 0), 32'd1);
         if (exp_cmd_q.size() != 0) check("cmd_data", cmd_data, exp_cmd_q.pop_front());
      end
   end

   task automatic wb_xfer(input logic w, input logic [7:0] off, input logic [31:0] d,
                          input logic [3:0] s, input logic pulse, output logic [31:0] rd);
      int n = 0;
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = w; adr = Base | {24'h0, off}; wdat = d; sel = s;
      if (pulse) cmd_ready = 1'b1;
      @(posedge clk); #1;
      check("ack_latency", 32'(ack), 32'd1);
      while (!ack && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      rd             = rdat;
      snap_gpio      = gpio_out;
      snap_cmd_valid = cmd_valid;
      @(negedge clk);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      if (pulse) cmd_ready = 1'b0;
      @(posedge clk); #1;
      check("ack_single_cycle", 32'(ack), 32'd0);
   endtask

   task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      wb_xfer(1'b1, off, d, s, 1'b0, dummy);
   endtask

   task automatic wb_read(input logic [7:0] off, output logic [31:0] rd);
      wb_xfer(1'b0, off, 32'h0, 4'hF, 1'b0, rd);
   endtask

   // Command write with the bench's own acceptance model (cmd_ready held low otherwise).
   task automatic cmd_write(input logic [31:0] d, input logic [3:0] s, input logic pulse);
      logic [31:0] dummy;
      if (s == 4'hF && (exp_cmd_q.size() < 4 || pulse)) exp_cmd_q.push_back(d);
      wb_xfer(1'b1, 8'h00, d, s, pulse, dummy);
   endtask

   task automatic rsp_read(input string tag);
      logic [31:0] rd;
      logic [31:0] exp;
      exp = (exp_rsp_q.size() != 0) ? exp_rsp_q.pop_front() : 32'h0;
      wb_read(8'h04, rd);
      check(tag, rd, exp);
   endtask

   task automatic drain_cmds(input string tag);
      int n = 0;
      @(negedge clk);
      cmd_ready = 1'b1;
      while (cmd_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, 32'(cmd_valid), 32'd0);
      @(negedge clk);
      cmd_ready = 1'b0;
      check("cmd_scoreboard_empty", 32'(exp_cmd_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dat", rdat, 32'h0);
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd_data", cmd_data, 32'h0);
      check("rst_rsp_ready", 32'(rsp_ready), 32'd1);
      check("rst_gpio_out", 32'(gpio_out), 32'h0);
      check("rst_gpio_oeb", 32'(gpio_oeb), 32'h0);
      check("rst_irq", 32'(irq), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wb_read(8'h08, r);
      check("rst_status", r, 32'h0000_000A);

      // Checkbit signature with byte-lane write
      wb_write(8'h0C, 32'h0000_AB60, 4'hF);
      check("gpio_start_at_ack", 32'(snap_gpio), 32'h0000_AB60);
      wb_write(8'h0C, 32'hFFFF_FF61, 4'h1);
      check("gpio_done", 32'(gpio_out), 32'h0000_AB61);
      wb_read(8'h0C, r);
      check("gpio_readback", r, 32'h0000_AB61);

      // Command overflow
      for (int i = 1; i <= 5; i++) begin
         cmd_write(32'(i), 4'hF, 1'b0);
         if (i == 1) check("cmd_valid_at_ack", 32'(snap_cmd_valid), 32'd1);
      end
      check("cmd_head", cmd_data, 32'd1);
      wb_read(8'h08, r);
      check("status_overflow", r, 32'h0001_0049);
      drain_cmds("cmd_drain1");
      wb_write(8'h08, 32'h0001_0000, 4'hF);
      wb_read(8'h08, r);
      check("status_ovf_cleared", r, 32'h0000_000A);

      // Partial sel on CMD is ignored
      cmd_write(32'h77, 4'h3, 1'b0);
      wb_read(8'h08, r);
      check("status_sel_ignored", r, 32'h0000_000A);

      // Full FIFO with simultaneous pop
      for (int i = 0; i < 4; i++) cmd_write(32'h10 + 32'(i), 4'hF, 1'b0);
      cmd_write(32'h14, 4'hF, 1'b1);
      wb_read(8'h08, r);
      check("status_full_pop", r, 32'h0000_0049);
      drain_cmds("cmd_drain2");

      // Unmapped offset inside the block
      wb_read(8'h20, r);
      check("unmapped_read", r, 32'h0);

      // Response path with interrupts
      wb_write(8'h10, 32'h0000_0003, 4'h1);
      @(negedge clk);
      rsp_valid = 1'b1; rsp_data = 32'hDEAD_0001; exp_rsp_q.push_back(rsp_data);
      @(posedge clk); #1;
      check("irq_lag", 32'(irq), 32'd0);
      @(negedge clk);
      rsp_data = 32'hDEAD_0002; exp_rsp_q.push_back(rsp_data);
      @(posedge clk); #1;
      check("irq_rise", 32'(irq), 32'd1);
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_read("rsp_rd0");
      rsp_read("rsp_rd1");
      rsp_read("rsp_rd_underflow");
      wb_read(8'h08, r);
      check("status_underflow", r, 32'h0002_000A);
      check("irq_err", 32'(irq), 32'd1);
      wb_write(8'h08, 32'h0003_0000, 4'hF);
      check("irq_drop", 32'(irq), 32'd0);
      wb_read(8'h08, r);
      check("status_udf_cleared", r, 32'h0000_000A);

      // Response FIFO full: fifth offered word is refused
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rsp_valid = 1'b1; rsp_data = 32'h100 + 32'(i);
         if (exp_rsp_q.size() < 4) exp_rsp_q.push_back(rsp_data);
         if (i == 4) begin
            #1;
            check("rsp_ready_full", 32'(rsp_ready), 32'd0);
         end
      end
      @(negedge clk);
      rsp_valid = 1'b0;
      wb_read(8'h08, r);
      check("status_rsp_full", r, 32'h0000_0406);
      for (int i = 0; i < 4; i++) rsp_read("rsp_full_rd");

      // Out-of-block address is never acked
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h4000_0008; sel = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("oob_no_ack", 32'(ack), 32'd0);
         check("oob_dat_zero", rdat, 32'h0);
      end
      @(negedge clk);
      stb = 1'b0; cyc = 1'b0;

      // Reset mid-operation
      wb_write(8'h0C, 32'h0000_1234, 4'hF);
      for (int i = 0; i < 3; i++) cmd_write(32'h21 + 32'(i), 4'hF, 1'b0);
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = Base | 32'h08; rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_no_ack", 32'(ack), 32'd0);
      check("rst_mid_cmd_valid", 32'(cmd_valid), 32'd0);
      @(negedge clk);
      stb = 1'b0; cyc = 1'b0; rst = 1'b0;
      exp_cmd_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rst_mid_ack_quiet", 32'(ack), 32'd0);
      end
      wb_read(8'h0C, r);
      check("rst_mid_gpio", r, 32'h0);
      wb_read(8'h08, r);
      check("rst_mid_status", r, 32'h0000_000A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
